rs_encoder_param: RTL and testbench

- Parametrised systematic Reed-Solomon encoder over GF(256); successor to the fixed RS(16,8) encoder.
- Supports any N/K with parity count R = N-K.
- Accepts shortened messages (1..K bytes, framed by sop/eop).
- Adds ready/valid backpressure on both sides and a framing-error flag.
- Sits between the framer and the line interface.

---
 rtl/rs_encoder_param.sv | 191 +++++++++++++++++++
 tb/tb_rs_encoder_param.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_encoder_param.sv
`default_nettype none
// ============================================================================
// Module   : rs_encoder_param
// Purpose  : Parametrised systematic Reed-Solomon encoder over GF(256).
//            Message bytes pass straight through to the output register.
//            After the last message byte, the R parity bytes held in the LFSR
//            follow, highest-order first. Shortened messages of 1..K bytes
//            are framed by sop/eop. Ready/valid handshakes are used on both
//            sides, and frm_err pulses for one cycle on a framing violation.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            i_din_val/sop/eop/din input byte stream and framing
//            o_din_rdy             encoder accepts a byte this cycle
//            o_dout_val/sop/eop    output stream valid and framing
//            o_dout                codeword byte (message then parity)
//            i_dout_rdy            downstream accepts the output byte
//            o_frm_err             one-cycle framing-violation pulse
// Revision : 1.0  initial parametrised release
// ============================================================================
module rs_encoder_param #(
  parameter int         N         = 16,
  parameter int         K         = 8,
  parameter int         FCR       = 0,
  parameter logic [8:0] PRIM_POLY = 9'h11D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_din_val,
  input  logic       i_din_sop,
  input  logic       i_din_eop,
  input  logic [7:0] i_din,
  output logic       o_din_rdy,
  output logic       o_dout_val,
  input  logic       i_dout_rdy,
  output logic       o_dout_sop,
  output logic       o_dout_eop,
  output logic [7:0] o_dout,
  output logic       o_frm_err
);

  localparam int         c_R      = N - K;
  localparam logic [7:0] c_K      = 8'(K);
  localparam logic [7:0] c_R_LAST = 8'(c_R - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DATA   = 2'd1;
  localparam logic [1:0] c_PARITY = 2'd2;

  // GF(256) multiply, shift-and-add with reduction by the field polynomial.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ PRIM_POLY[7:0]) : {x[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Generator polynomial prod (x + alpha^(FCR+i)); the monic x^R term is
  // implicit, so only g_0..g_{R-1} are returned (g_i in byte lane i).
  function automatic logic [8*c_R-1:0] gen_poly();
    logic [7:0]       g [0:c_R];
    logic [7:0]       root;
    logic [8*c_R-1:0] res;
    for (int j = 0; j <= c_R; j++) g[j] = 8'h00;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < FCR; i++) root = gf_mul(root, 8'h02);
    for (int i = 0; i < c_R; i++) begin
      for (int j = c_R; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    res = '0;
    for (int j = 0; j < c_R; j++) res[8*j +: 8] = g[j];
    return res;
  endfunction

  localparam logic [8*c_R-1:0] c_GEN = gen_poly();

  logic [1:0]       r_state;
  logic [7:0]       r_cnt;
  logic [8*c_R-1:0] r_par;
  logic             r_run;
  logic             r_dout_val;
  logic             r_dout_sop;
  logic             r_dout_eop;
  logic [7:0]       r_dout;
  logic             r_frm_err;

  logic             w_adv;
  logic             w_din_rdy;
  logic             w_in_fire;
  logic [8*c_R-1:0] w_par_base;
  logic [8*c_R-1:0] w_par_feed;
  logic [8*c_R-1:0] w_par_shift;
  logic [7:0]       w_fb;
  logic [7:0]       w_cnt_feed;
  logic             w_hit_k;

  // r_run keeps din_rdy low during and immediately after reset; the ready
  // term never depends on i_din_val.
  assign w_adv     = ~r_dout_val | i_dout_rdy;
  assign w_din_rdy = r_run & (r_state != c_PARITY) & w_adv;
  assign w_in_fire = i_din_val & w_din_rdy;

  // A sop byte always starts from a cleared LFSR (fresh frame or abort).
  assign w_par_base  = i_din_sop ? '0 : r_par;
  assign w_fb        = i_din ^ w_par_base[8*c_R-1 -: 8];
  assign w_par_shift = {r_par[8*c_R-9:0], 8'h00};
  assign w_cnt_feed  = i_din_sop ? 8'd1 : (r_cnt + 8'd1);
  assign w_hit_k     = (w_cnt_feed == c_K);

  assign w_par_feed[7:0] = gf_mul(w_fb, c_GEN[7:0]);
  for (genvar gi = 1; gi < c_R; gi++) begin : g_tap
    assign w_par_feed[8*gi +: 8] = w_par_base[8*(gi-1) +: 8] ^ gf_mul(w_fb, c_GEN[8*gi +: 8]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_cnt      <= 8'd0;
      r_par      <= '0;
      r_run      <= 1'b0;
      r_dout_val <= 1'b0;
      r_dout_sop <= 1'b0;
      r_dout_eop <= 1'b0;
      r_dout     <= 8'h00;
      r_frm_err  <= 1'b0;
    end else begin
      r_run     <= 1'b1;
      r_frm_err <= 1'b0;
      case (r_state)
        c_IDLE, c_DATA: begin
          if (w_in_fire) begin
            if ((r_state == c_IDLE) && !i_din_sop) begin
              // Stray byte outside a frame: drop it.
              r_frm_err  <= 1'b1;
              r_dout_val <= 1'b0;
            end else begin
              r_dout_val <= 1'b1;
              r_dout     <= i_din;
              r_dout_sop <= i_din_sop;
              r_dout_eop <= 1'b0;
              r_par      <= w_par_feed;
              if (i_din_eop || w_hit_k) begin
                r_state <= c_PARITY;
                r_cnt   <= 8'd0;
              end else begin
                r_state <= c_DATA;
                r_cnt   <= w_cnt_feed;
              end
              // Abort of a running frame, or K bytes without eop.
              if (((r_state == c_DATA) && i_din_sop) || (w_hit_k && !i_din_eop))
                r_frm_err <= 1'b1;
            end
          end else if (w_adv) begin
            r_dout_val <= 1'b0;
          end
        end
        c_PARITY: begin
          if (w_adv) begin
            r_dout_val <= 1'b1;
            r_dout     <= r_par[8*c_R-1 -: 8];
            r_dout_sop <= 1'b0;
            r_dout_eop <= (r_cnt == c_R_LAST);
            r_par      <= w_par_shift;
            if (r_cnt == c_R_LAST) begin
              r_state <= c_IDLE;
              r_cnt   <= 8'd0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign o_din_rdy  = w_din_rdy;
  assign o_dout_val = r_dout_val;
  assign o_dout_sop = r_dout_sop;
  assign o_dout_eop = r_dout_eop;
  assign o_dout     = r_dout;
  assign o_frm_err  = r_frm_err;

endmodule
`default_nettype wire

// File: tb/tb_rs_encoder_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_encoder_param
// Purpose  : Self-checking bench for rs_encoder_param. Three instances
//            (16/8, 255/223, 12/4 with FCR=1) share the stimulus, and the
//            input valid is steered to one of them. Codewords are checked
//            against a log/antilog GF(256) model: message passthrough,
//            length, and all R syndromes zero.
// Revision : 1.0  initial release
// ============================================================================
module tb_rs_encoder_param;

  localparam int N0 = 16,  K0 = 8,   F0 = 0, R0 = N0 - K0;
  localparam int N1 = 255, K1 = 223, F1 = 0, R1 = N1 - K1;
  localparam int N2 = 12,  K2 = 4,   F2 = 1, R2 = N2 - K2;

  logic       clk;
  logic       rst_n;
  logic       din_val, din_sop, din_eop;
  logic [7:0] din;
  logic       dout_rdy;
  logic [1:0] sel;
  logic [2:0] gval;
  logic       rdy [3];
  logic       val [3];
  logic       sop [3];
  logic       eop [3];
  logic       err [3];
  logic [7:0] dq  [3];
  logic       m_rdy, m_val, m_sop, m_eop, m_err;
  logic [7:0] m_dout;

  int n_chk = 0, n_fail = 0;
  int cur_R, cur_fcr, cur_K;
  int exp_t [0:510];
  int log_t [0:255];
  int gp [0:32];
  logic [7:0] cw[$], last_cw[$], tx_q[$], exp_b[$];
  int exp_len[$];
  int err_cnt = 0, fire_cnt = 0, stall_cnt = 0, cyc = 0;
  int last_fire_cyc = 0, tp_first = 0;
  bit tp_arm = 0, rand_mode = 0, rdy_force = 1, held_v = 0;
  logic [10:0] held_w;

  always_comb begin
    for (int i = 0; i < 3; i++) gval[i] = din_val && (sel == 2'(i));
  end

  always_comb begin
    case (sel)
      2'd1:    begin m_rdy = rdy[1]; m_val = val[1]; m_sop = sop[1]; m_eop = eop[1]; m_err = err[1]; m_dout = dq[1]; end
      2'd2:    begin m_rdy = rdy[2]; m_val = val[2]; m_sop = sop[2]; m_eop = eop[2]; m_err = err[2]; m_dout = dq[2]; end
      default: begin m_rdy = rdy[0]; m_val = val[0]; m_sop = sop[0]; m_eop = eop[0]; m_err = err[0]; m_dout = dq[0]; end
    endcase
  end

  rs_encoder_param #(.N(N0), .K(K0), .FCR(F0), .PRIM_POLY(9'h11D)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_din_val(gval[0]), .i_din_sop(din_sop), .i_din_eop(din_eop),
    .i_din(din), .o_din_rdy(rdy[0]), .o_dout_val(val[0]), .i_dout_rdy(dout_rdy),
    .o_dout_sop(sop[0]), .o_dout_eop(eop[0]), .o_dout(dq[0]), .o_frm_err(err[0]));

  rs_encoder_param #(.N(N1), .K(K1), .FCR(F1), .PRIM_POLY(9'h11D)) u_dut_big (
    .clk(clk), .rst_n(rst_n), .i_din_val(gval[1]), .i_din_sop(din_sop), .i_din_eop(din_eop),
    .i_din(din), .o_din_rdy(rdy[1]), .o_dout_val(val[1]), .i_dout_rdy(dout_rdy),
    .o_dout_sop(sop[1]), .o_dout_eop(eop[1]), .o_dout(dq[1]), .o_frm_err(err[1]));

  rs_encoder_param #(.N(N2), .K(K2), .FCR(F2), .PRIM_POLY(9'h11D)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .i_din_val(gval[2]), .i_din_sop(din_sop), .i_din_eop(din_eop),
    .i_din(din), .o_din_rdy(rdy[2]), .o_dout_val(val[2]), .i_dout_rdy(dout_rdy),
    .o_dout_sop(sop[2]), .o_dout_eop(eop[2]), .o_dout(dq[2]), .o_frm_err(err[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- GF(256) reference model ----------------
  task automatic init_gf();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    for (int i = 255; i <= 510; i++) exp_t[i] = exp_t[i-255];
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[log_t[a] + log_t[b]];
  endfunction

  // Evaluate the received codeword polynomial at alpha^(FCR+j) (Horner).
  function automatic int syndrome(input int j);
    int root, s;
    root = exp_t[(cur_fcr + j) % 255];
    s = 0;
    foreach (cw[k]) s = gmul(s, root) ^ int'(cw[k]);
    return s;
  endfunction

  // Expand prod (x + alpha^(fcr+i)); gp[i] is the coefficient of x^i.
  task automatic build_gen();
    int root;
    for (int i = 0; i <= 32; i++) gp[i] = 0;
    gp[0] = 1;
    for (int i = 0; i < cur_R; i++) begin
      root = exp_t[(cur_fcr + i) % 255];
      for (int k = cur_R; k > 0; k--) gp[k] = gp[k-1] ^ gmul(gp[k], root);
      gp[0] = gmul(gp[0], root);
    end
  endtask

  task automatic check_cw();
    int L, nz;
    logic [7:0] b;
    if (exp_len.size() == 0) begin
      chk("unexpected_codeword_len", cw.size(), 0);
    end else begin
      L = exp_len.pop_front();
      chk("cw_len", cw.size(), L + cur_R);
      for (int i = 0; i < L; i++) begin
        b = exp_b.pop_front();
        if (i < cw.size()) chk("cw_msg_byte", cw[i], b);
      end
      nz = 0;
      for (int j = 0; j < cur_R; j++) if (syndrome(j) != 0) nz++;
      chk("cw_nonzero_syndromes", nz, 0);
    end
    last_cw = cw;
    cw.delete();
  endtask

  // ---------------- output monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        cw.delete();
        exp_len.delete();
        exp_b.delete();
        held_v = 0;
      end else begin
        if (m_err) err_cnt++;
        if (held_v) chk("held_output_stable", {m_val, m_sop, m_eop, m_dout}, held_w);
        held_v = m_val && !dout_rdy;
        held_w = {m_val, m_sop, m_eop, m_dout};
        if (m_val && dout_rdy) begin
          fire_cnt++;
          last_fire_cyc = cyc;
          if (tp_arm) begin tp_first = cyc; tp_arm = 0; end
          if (m_sop) cw.delete();
          if (!m_sop && cw.size() == 0) chk("orphan_byte_sop", m_sop, 1);
          else cw.push_back(m_dout);
          if (m_eop && cw.size() != 0) check_cw();
        end
      end
    end
  end

  // ---------------- output ready driver ----------------
  initial begin
    dout_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dout_rdy = rand_mode ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_byte(input logic [7:0] d, input bit s, input bit e);
    int waited;
    din = d; din_sop = s; din_eop = e; din_val = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!m_rdy && waited < 2000) begin
      stall_cnt++;
      waited++;
      @(negedge clk);
    end
    if (!m_rdy) chk("din_rdy_timeout_cycles", waited, 0);
    @(posedge clk);
    #1;
    din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask

  task automatic rand_msg(input int len);
    tx_q.delete();
    for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_frame(input bit mark_eop, input bit push, input bit gaps);
    if (push) begin
      exp_len.push_back(tx_q.size());
      foreach (tx_q[i]) exp_b.push_back(tx_q[i]);
    end
    for (int i = 0; i < tx_q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      drive_byte(tx_q[i], i == 0, mark_eop && (i == tx_q.size() - 1));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_len.size() != 0 || cw.size() != 0 || m_val) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", (t >= 20000) ? 1 : 0, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [1:0] s);
    sel = s;
    cur_R   = (s == 2'd1) ? R1 : (s == 2'd2) ? R2 : R0;
    cur_K   = (s == 2'd1) ? K1 : (s == 2'd2) ? K2 : K0;
    cur_fcr = (s == 2'd1) ? F1 : (s == 2'd2) ? F2 : F0;
  endtask

  task automatic check_zero_outputs(input string ph);
    chk({ph, "_dout_val"}, m_val, 0);
    chk({ph, "_dout_sop"}, m_sop, 0);
    chk({ph, "_dout_eop"}, m_eop, 0);
    chk({ph, "_dout"}, m_dout, 0);
    chk({ph, "_frm_err"}, m_err, 0);
    chk({ph, "_din_rdy"}, m_rdy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e0, f0, s0, nz, hi;
    logic [7:0] a, b;
    init_gf();
    set_sel(2'd0);
    rst_n = 1'b0; din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din = 8'h00;
    #3;
    check_zero_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rdy_after_por", m_rdy, 1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of the parity phase.
    rand_msg(4);
    send_frame(1, 1, 0);
    @(negedge clk);
    chk("in_parity_din_rdy", m_rdy, 0);
    chk("in_parity_dout_val", m_val, 1);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rdy_after_release", m_rdy, 1);
    @(posedge clk); #1;

    // Known vectors: all-zero message, then single byte 0x01.
    tx_q.delete();
    for (int i = 0; i < K0; i++) tx_q.push_back(8'h00);
    send_frame(1, 1, 0);
    drain();
    nz = 0;
    foreach (last_cw[i]) if (last_cw[i] != 8'h00) nz++;
    chk("kv_zero_len", last_cw.size(), N0);
    chk("kv_zero_nonzero_bytes", nz, 0);
    tx_q.delete();
    tx_q.push_back(8'h01);
    send_frame(1, 1, 0);
    drain();
    build_gen();
    chk("kv_one_len", last_cw.size(), 1 + R0);
    chk("kv_one_msg", last_cw[0], 1);
    for (int i = 0; i < R0; i++) chk("kv_one_gen_coef", last_cw[1 + i], gp[R0 - 1 - i]);

    // Framing errors.
    e0 = err_cnt;
    drive_byte(8'h55, 0, 0);
    @(negedge clk);
    chk("nosop_frm_err_pulse", m_err, 1);
    @(posedge clk); #1;
    drain();
    chk("nosop_err_count", err_cnt - e0, 1);
    rand_msg(3);
    send_frame(0, 0, 0);
    rand_msg(5);
    send_frame(1, 1, 0);
    drain();
    chk("abort_err_count", err_cnt - e0, 2);
    rand_msg(K0);
    send_frame(0, 1, 0);
    @(negedge clk);
    chk("force_k_frm_err_pulse", m_err, 1);
    @(posedge clk); #1;
    drain();
    chk("force_k_err_count", err_cnt - e0, 3);

    // Output held low for a long time: no loss, input stays blocked.
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    tx_q.delete(); tx_q.push_back(a); tx_q.push_back(b);
    exp_len.push_back(2); exp_b.push_back(a); exp_b.push_back(b);
    rdy_force = 0;
    drive_byte(a, 1, 0);
    din = b; din_sop = 1'b0; din_eop = 1'b1; din_val = 1'b1;
    hi = 0;
    repeat (40) begin @(negedge clk); if (m_rdy) hi++; end
    chk("stall_din_rdy_high_cycles", hi, 0);
    rdy_force = 1;
    drive_byte(b, 0, 1);
    drain();

    // Random full and shortened frames with random backpressure.
    e0 = err_cnt;
    rand_mode = 1;
    for (int f = 0; f < 1000; f++) begin
      rand_msg($urandom_range(1, K0));
      send_frame(1, 1, 1);
    end
    drain();
    rand_mode = 0;
    chk("random_err_count", err_cnt - e0, 0);

    // Throughput: back-to-back frames with dout_rdy held high.
    drain();
    f0 = fire_cnt; s0 = stall_cnt; tp_arm = 1;
    for (int f = 0; f < 4; f++) begin
      rand_msg(5);
      send_frame(1, 1, 0);
    end
    drain();
    chk("tp_output_bytes", fire_cnt - f0, 4 * (5 + R0));
    chk("tp_contiguous_span", last_fire_cyc - tp_first + 1, fire_cnt - f0);
    chk("tp_din_rdy_low_cycles", stall_cnt - s0, 3 * R0);

    // Parameter sweep: RS(255,223) and RS(12,4) with FCR=1.
    set_sel(2'd1);
    rand_mode = 1;
    rand_msg(K1); send_frame(1, 1, 0);
    rand_msg(1);  send_frame(1, 1, 0);
    rand_msg($urandom_range(1, K1)); send_frame(1, 1, 1);
    drain();
    chk("big_last_len", last_cw.size() >= R1 + 1, 1);
    set_sel(2'd2);
    for (int f = 0; f < 40; f++) begin
      rand_msg($urandom_range(1, K2));
      send_frame(1, 1, 1);
    end
    drain();
    rand_mode = 0;
    set_sel(2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
